// File: rtl/ex_mem_skid_reg.sv
// ex_mem_skid_reg: EX->MEM register with valid/ready, 2-entry skid buffer, flush, optional stall counter (EXMEM_STALL_CNT_EN)
module ex_mem_skid_reg #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 9,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] store_data,
  input  logic [CTRL_W-1:0] ctrl_in,
  input  logic [REG_AW-1:0] rd_in,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] address,
  output logic [DATA_W-1:0] write_data,
  output logic [CTRL_W-1:0] ctrl_sig,
  output logic [REG_AW-1:0] rd
`ifdef EXMEM_STALL_CNT_EN
  ,
  output logic [31:0]       stall_cnt
`endif
);
  localparam int W = 2*DATA_W + CTRL_W + REG_AW;
  logic         main_v, skid_v, acc, pop;
  logic [W-1:0] main_d, skid_d, in_d;
  logic [CTRL_W-1:0] main_ctrl;
  assign in_d = {alu_result, store_data, ctrl_in, rd_in};
  assign {address, write_data, main_ctrl, rd} = main_d;
  assign in_ready  = ~skid_v;
  assign out_valid = main_v;
  assign ctrl_sig  = main_v ? main_ctrl : '0;
  assign acc = in_valid & in_ready;
  assign pop = main_v & out_ready;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
      main_d <= '0;
      skid_d <= '0;
    end else if (flush) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
    end else if (skid_v) begin
      if (pop) begin
        main_d <= skid_d;
        skid_v <= 1'b0;
      end
    end else if (~main_v | pop) begin
      main_v <= acc;
      if (acc) main_d <= in_d;
    end else if (acc) begin
      skid_v <= 1'b1;
      skid_d <= in_d;
    end
  end
`ifdef EXMEM_STALL_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) stall_cnt <= '0;
    else if (main_v & ~out_ready & ~&stall_cnt) stall_cnt <= stall_cnt + 32'd1;
  end
`endif
endmodule

// File: tb/tb_ex_mem_skid_reg.sv
// tb_ex_mem_skid_reg: randomized and directed checks against a 2-deep FIFO reference model
module tb_ex_mem_skid_reg;
  typedef struct packed {
    logic [31:0] a;
    logic [31:0] w;
    logic [8:0]  c;
    logic [4:0]  r;
  } beat_t;
  logic        clk = 1'b0, rst = 1'b1;
  logic        in_valid = 1'b0, in_ready, flush = 1'b0, out_valid, out_ready = 1'b0;
  logic [31:0] alu_result = '0, store_data = '0, address, write_data;
  logic [8:0]  ctrl_in = '0, ctrl_sig;
  logic [4:0]  rd_in = '0, rd;
`ifdef EXMEM_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif
  beat_t q[$];
  int    exp_stall = 0;
  int    n_pass = 0, n_tot = 0;

  ex_mem_skid_reg dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .alu_result(alu_result), .store_data(store_data), .ctrl_in(ctrl_in), .rd_in(rd_in),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .address(address), .write_data(write_data), .ctrl_sig(ctrl_sig), .rd(rd)
`ifdef EXMEM_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [79:0] obs();
    return {out_valid, in_ready, out_valid ? address : 32'h0, out_valid ? write_data : 32'h0,
            ctrl_sig, out_valid ? rd : 5'h0};
  endfunction

  function automatic logic [79:0] expv();
    if (q.size() == 0) return {1'b0, 1'b1, 78'h0};
    return {1'b1, q.size() < 2, q[0].a, q[0].w, q[0].c, q[0].r};
  endfunction

  // drive one cycle at negedge, advance the model at posedge, return at next negedge
  task automatic cyc(input logic v, input beat_t b, input logic ordy, input logic fl);
    logic acc, pop;
    in_valid = v; alu_result = b.a; store_data = b.w; ctrl_in = b.c; rd_in = b.r;
    out_ready = ordy; flush = fl;
    acc = v && q.size() < 2;
    pop = q.size() > 0 && ordy;
    if (q.size() > 0 && !ordy && exp_stall != 32'hFFFF_FFFF) exp_stall++;
    @(posedge clk);
    if (fl) q.delete();
    else begin
      if (pop) void'(q.pop_front());
      if (acc) q.push_back(b);
    end
    @(negedge clk);
  endtask

  function automatic beat_t mk(input logic [31:0] a, input logic [4:0] r);
    return '{a: a, w: ~a, c: a[8:0] | 9'h1, r: r};
  endfunction

  task automatic test_reset();
    cyc(1, mk(32'hA, 3), 0, 0);
    cyc(1, mk(32'hB, 7), 0, 0);
    n_tot++; if (obs() !== expv()) $display("FAIL reset_prefill got=%h exp=%h", obs(), expv()); else n_pass++;
    #3 rst = 1'b1;
    #1;
    n_tot++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", out_valid); else n_pass++;
    n_tot++; if (ctrl_sig !== 9'h0) $display("FAIL reset_ctrl_sig got=%h exp=0", ctrl_sig); else n_pass++;
    n_tot++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b exp=1", in_ready); else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    exp_stall = 0;
    cyc(0, '0, 1, 0);
    n_tot++; if (obs() !== expv()) $display("FAIL reset_no_replay got=%h exp=%h", obs(), expv()); else n_pass++;
`ifdef EXMEM_STALL_CNT_EN
    n_tot++; if (stall_cnt !== 32'd0) $display("FAIL reset_stall_cnt got=%0d exp=0", stall_cnt); else n_pass++;
`endif
  endtask

  task automatic test_stream();
    for (int i = 1; i <= 4; i++) begin
      cyc(1, mk(32'h10 * i, 5'(i)), 1, 0);
      n_tot++;
      if (address !== 32'h10 * i || out_valid !== 1'b1 || in_ready !== 1'b1)
        $display("FAIL stream_%0d got addr=%h v=%b rdy=%b exp addr=%h v=1 rdy=1", i, address, out_valid, in_ready, 32'h10 * i);
      else n_pass++;
      n_tot++; if (obs() !== expv()) $display("FAIL stream_model_%0d got=%h exp=%h", i, obs(), expv()); else n_pass++;
    end
    cyc(0, '0, 1, 0);
    n_tot++; if (out_valid !== 1'b0) $display("FAIL stream_drain got=%b exp=0", out_valid); else n_pass++;
  endtask

  task automatic test_skid();
    cyc(1, mk(32'hA0, 3), 0, 0);
    cyc(1, mk(32'hB0, 7), 0, 0);
    n_tot++;
    if (rd !== 5'd3 || in_ready !== 1'b0 || out_valid !== 1'b1)
      $display("FAIL skid_full got rd=%0d rdy=%b v=%b exp rd=3 rdy=0 v=1", rd, in_ready, out_valid);
    else n_pass++;
    cyc(1, mk(32'hC0, 9), 0, 0);
    n_tot++; if (obs() !== expv()) $display("FAIL skid_hold got=%h exp=%h", obs(), expv()); else n_pass++;
    cyc(0, '0, 1, 0);
    n_tot++; if (rd !== 5'd7 || out_valid !== 1'b1) $display("FAIL skid_b got rd=%0d v=%b exp rd=7 v=1", rd, out_valid); else n_pass++;
    n_tot++; if (obs() !== expv()) $display("FAIL skid_b_model got=%h exp=%h", obs(), expv()); else n_pass++;
    cyc(0, '0, 1, 0);
    n_tot++; if (out_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL skid_drain got v=%b rdy=%b exp v=0 rdy=1", out_valid, in_ready); else n_pass++;
  endtask

  task automatic test_flush();
    cyc(1, mk(32'hA1, 3), 0, 0);
    cyc(1, mk(32'hB1, 7), 0, 0);
    cyc(1, mk(32'hC1, 11), 0, 1);
    n_tot++;
    if (out_valid !== 1'b0 || ctrl_sig !== 9'h0 || in_ready !== 1'b1)
      $display("FAIL flush_full got v=%b ctrl=%h rdy=%b exp v=0 ctrl=0 rdy=1", out_valid, ctrl_sig, in_ready);
    else n_pass++;
    cyc(1, mk(32'hD1, 13), 1, 1);
    n_tot++; if (out_valid !== 1'b0) $display("FAIL flush_same_cycle_acc got=%b exp=0", out_valid); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      cyc(0, '0, 1, 0);
      n_tot++; if (out_valid !== 1'b0) $display("FAIL flush_ghost_%0d got=%b exp=0", i, out_valid); else n_pass++;
    end
  endtask

  task automatic test_bubble();
    beat_t b;
    b = '{a: 32'h55, w: 32'h66, c: 9'h1FF, r: 5'd31};
    for (int i = 0; i < 3; i++) begin
      cyc(0, b, i[0], 0);
      n_tot++; if (ctrl_sig !== 9'h0 || out_valid !== 1'b0) $display("FAIL bubble_%0d got ctrl=%h v=%b exp ctrl=0 v=0", i, ctrl_sig, out_valid); else n_pass++;
    end
  endtask

`ifdef EXMEM_STALL_CNT_EN
  task automatic test_stall_cnt();
    rst = 1'b1; #1 rst = 1'b0;
    q.delete(); exp_stall = 0;
    cyc(1, mk(32'h77, 2), 0, 0);
    for (int i = 0; i < 5; i++) cyc(0, '0, 0, 0);
    n_tot++; if (stall_cnt !== 32'd5) $display("FAIL stall_cnt_5 got=%0d exp=5", stall_cnt); else n_pass++;
    cyc(0, '0, 1, 1);
    cyc(0, '0, 0, 0);
    n_tot++; if (stall_cnt !== 32'd5) $display("FAIL stall_cnt_flush got=%0d exp=5", stall_cnt); else n_pass++;
    rst = 1'b1; #1;
    n_tot++; if (stall_cnt !== 32'd0) $display("FAIL stall_cnt_rst got=%0d exp=0", stall_cnt); else n_pass++;
    rst = 1'b0; exp_stall = 0;
    @(negedge clk);
  endtask
`endif

  task automatic test_random();
    int errs = 0;
    beat_t b;
    for (int i = 0; i < 400; i++) begin
      b = '{a: $urandom, w: $urandom, c: 9'($urandom), r: 5'($urandom)};
      cyc(1'($urandom_range(0, 3) != 0), b, 1'($urandom_range(0, 2) != 0), $urandom_range(0, 24) == 0);
      n_tot++;
      if (obs() !== expv()) begin
        if (errs < 10) $display("FAIL random_%0d got=%h exp=%h", i, obs(), expv());
        errs++;
      end else n_pass++;
`ifdef EXMEM_STALL_CNT_EN
      n_tot++;
      if (stall_cnt !== 32'(exp_stall)) begin
        if (errs < 10) $display("FAIL random_stall_%0d got=%0d exp=%0d", i, stall_cnt, exp_stall);
        errs++;
      end else n_pass++;
`endif
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_stream();
    test_skid();
    test_flush();
    test_bubble();
`ifdef EXMEM_STALL_CNT_EN
    test_stall_cnt();
`endif
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
